// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the decode-to-execute pipeline bundle.
// Instruction codes, special register ids and the bubble value live here.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] RRSP   = 4'h4;

    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [63:0] valC;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic        ins_err;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        valid:   1'b0,
        icode:   NOP,
        ifun:    4'h0,
        valA:    64'h0,
        valB:    64'h0,
        valC:    64'h0,
        dstE:    RNONE,
        dstM:    RNONE,
        srcA:    RNONE,
        srcB:    RNONE,
        ins_err: 1'b0
    };

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x 64, two read ports, two write ports.
// Reads see same-cycle writes; port M wins a same-destination collision.
module y86_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_srcA,
    input  logic [3:0]  i_srcB,
    input  logic [3:0]  i_dstE,
    input  logic [63:0] i_valE,
    input  logic [3:0]  i_dstM,
    input  logic [63:0] i_valM,
    output logic [63:0] o_valA,
    output logic [63:0] o_valB
);

    logic [63:0] r_regs [15];

    // Write-through read: pending M write, then E write, then stored value
    function automatic logic [63:0] rd(input logic [3:0] id);
        logic [63:0] v;
        if (id == RNONE)
            v = 64'h0;
        else if (id == i_dstM)
            v = i_valM;
        else if (id == i_dstE)
            v = i_valE;
        else
            v = r_regs[id];
        return v;
    endfunction

    // Combinational read ports with bypass
    always_comb begin
        o_valA = rd(i_srcA);
        o_valB = rd(i_srcB);
    end

    // Storage update; reset clears and blocks write-back, M written last wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                r_regs[i] <= 64'h0;
        end else begin
            if (i_dstE != RNONE)
                r_regs[i_dstE] <= i_valE;
            if (i_dstM != RNONE)
                r_regs[i_dstM] <= i_valM;
        end
    end

endmodule

// File: rtl/decode_wb.sv
// Y86-64 decode / write-back stage with the E pipeline register.
// Decodes register ids, reads operands and handles stall/bubble control.
module decode_wb
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        stall,
    input  logic        bubble,
    input  logic [3:0]  wb_dstE,
    input  logic [63:0] wb_valE,
    input  logic [3:0]  wb_dstM,
    input  logic [63:0] wb_valM,
    output logic        e_valid,
    output logic [3:0]  e_icode,
    output logic [3:0]  e_ifun,
    output logic [63:0] e_valA,
    output logic [63:0] e_valB,
    output logic [63:0] e_valC,
    output logic [3:0]  e_dstE,
    output logic [3:0]  e_dstM,
    output logic [3:0]  e_srcA,
    output logic [3:0]  e_srcB,
    output logic        e_ins_err
);

    logic [3:0]  w_srcA;
    logic [3:0]  w_srcB;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic [63:0] w_rdA;
    logic [63:0] w_rdB;
    logic        w_bad;
    e_reg_t      w_next;
    e_reg_t      r_e;

    assign w_bad = (icode > POPQ);

    // Register-id decode; unknown icodes fall through to RNONE
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (icode)
            RRMOVQ, RMMOVQ, OPQ, PUSHQ: w_srcA = rA;
            RET, POPQ:                  w_srcA = RRSP;
            default:                    ;
        endcase
        case (icode)
            RMMOVQ, MRMOVQ, OPQ:        w_srcB = rB;
            CALL, RET, PUSHQ, POPQ:     w_srcB = RRSP;
            default:                    ;
        endcase
        case (icode)
            RRMOVQ, IRMOVQ, OPQ:        w_dstE = rB;
            CALL, RET, PUSHQ, POPQ:     w_dstE = RRSP;
            default:                    ;
        endcase
        case (icode)
            MRMOVQ, POPQ:               w_dstM = rA;
            default:                    ;
        endcase
    end

    y86_regfile u_rf (
        .clk    (clk),
        .rst    (rst),
        .i_srcA (w_srcA),
        .i_srcB (w_srcB),
        .i_dstE (wb_dstE),
        .i_valE (wb_valE),
        .i_dstM (wb_dstM),
        .i_valM (wb_valM),
        .o_valA (w_rdA),
        .o_valB (w_rdB)
    );

    // Assemble the bundle for a valid instruction
    always_comb begin
        w_next         = E_BUBBLE;
        w_next.valid   = 1'b1;
        w_next.icode   = icode;
        w_next.ifun    = ifun;
        w_next.valC    = valC;
        w_next.srcA    = w_srcA;
        w_next.srcB    = w_srcB;
        w_next.dstE    = w_dstE;
        w_next.dstM    = w_dstM;
        w_next.ins_err = w_bad;
        w_next.valB    = w_rdB;
        if (icode == JXX || icode == CALL)
            w_next.valA = valP;
        else
            w_next.valA = w_rdA;
    end

    // E register: reset beats stall, stall beats bubble
    always_ff @(posedge clk) begin
        if (rst)
            r_e <= E_BUBBLE;
        else if (!stall) begin
            if (bubble || !in_valid)
                r_e <= E_BUBBLE;
            else
                r_e <= w_next;
        end
    end

    assign e_valid   = r_e.valid;
    assign e_icode   = r_e.icode;
    assign e_ifun    = r_e.ifun;
    assign e_valA    = r_e.valA;
    assign e_valB    = r_e.valB;
    assign e_valC    = r_e.valC;
    assign e_dstE    = r_e.dstE;
    assign e_dstM    = r_e.dstM;
    assign e_srcA    = r_e.srcA;
    assign e_srcB    = r_e.srcB;
    assign e_ins_err = r_e.ins_err;

endmodule

// File: tb/tb_decode_wb.sv
// Self-checking bench for decode_wb: reference model plus directed vectors.
// Model applies writes to a copy of the register file and reads from it.
module tb_decode_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        stall, bubble;
    logic [3:0]  wb_dstE, wb_dstM;
    logic [63:0] wb_valE, wb_valM;
    logic        e_valid;
    logic [3:0]  e_icode, e_ifun;
    logic [63:0] e_valA, e_valB, e_valC;
    logic [3:0]  e_dstE, e_dstM, e_srcA, e_srcB;
    logic        e_ins_err;

    int n_chk = 0;
    int n_fail = 0;

    decode_wb dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP),
        .stall(stall), .bubble(bubble),
        .wb_dstE(wb_dstE), .wb_valE(wb_valE),
        .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC),
        .e_dstE(e_dstE), .e_dstM(e_dstM),
        .e_srcA(e_srcA), .e_srcB(e_srcB), .e_ins_err(e_ins_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] mregs [15];
    logic [63:0] nregs [15];
    logic        m_valid, m_err;
    logic [3:0]  m_icode, m_ifun, m_sA, m_sB, m_dE, m_dM;
    logic [63:0] m_vA, m_vB, m_vC;

    function automatic logic [63:0] mrd(input logic [3:0] id);
        if (id == 4'hF) return 64'h0;
        return nregs[id];
    endfunction

    task automatic m_bubble();
        m_valid = 0; m_icode = 4'h1; m_ifun = 0; m_err = 0;
        m_vA = 0; m_vB = 0; m_vC = 0;
        m_sA = 4'hF; m_sB = 4'hF; m_dE = 4'hF; m_dM = 4'hF;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            foreach (mregs[i]) mregs[i] = 64'h0;
            m_bubble();
        end else begin
            foreach (mregs[i]) nregs[i] = mregs[i];
            if (wb_dstE != 4'hF) nregs[wb_dstE] = wb_valE;
            if (wb_dstM != 4'hF) nregs[wb_dstM] = wb_valM;
            if (!stall) begin
                if (bubble || !in_valid) m_bubble();
                else begin
                    m_valid = 1; m_icode = icode; m_ifun = ifun; m_vC = valC;
                    m_err = (icode > 4'hB);
                    m_sA = 4'hF; m_sB = 4'hF; m_dE = 4'hF; m_dM = 4'hF;
                    if (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) m_sA = rA;
                    if (icode inside {4'h9, 4'hB}) m_sA = 4'h4;
                    if (icode inside {4'h4, 4'h5, 4'h6}) m_sB = rB;
                    if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) m_sB = 4'h4;
                    if (icode inside {4'h2, 4'h3, 4'h6}) m_dE = rB;
                    if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) m_dE = 4'h4;
                    if (icode inside {4'h5, 4'hB}) m_dM = rA;
                    m_vA = (icode == 4'h7 || icode == 4'h8) ? valP : mrd(m_sA);
                    m_vB = mrd(m_sB);
                end
            end
            foreach (mregs[i]) mregs[i] = nregs[i];
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic cmp_model();
        chk("valid", 64'(e_valid), 64'(m_valid));
        chk("ins_err", 64'(e_ins_err), 64'(m_err));
        chk("valA", e_valA, m_vA);
        chk("valB", e_valB, m_vB);
        chk("srcA", 64'(e_srcA), 64'(m_sA));
        chk("srcB", 64'(e_srcB), 64'(m_sB));
        chk("dstE", 64'(e_dstE), 64'(m_dE));
        chk("dstM", 64'(e_dstM), 64'(m_dM));
        if (!m_err) begin
            chk("icode", 64'(e_icode), 64'(m_icode));
            chk("ifun", 64'(e_ifun), 64'(m_ifun));
            chk("valC", e_valC, m_vC);
        end
    endtask

    task automatic ins(input logic iv, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] c, input logic [63:0] p);
        in_valid = iv; icode = ic; ifun = fn; rA = a; rB = b; valC = c; valP = p;
    endtask

    task automatic ctl(input logic r, input logic s, input logic b);
        rst = r; stall = s; bubble = b;
    endtask

    task automatic wb(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
        wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        ctl(1, 0, 0);
        ins(1, 4'h3, 0, 4'hF, 4'h2, 64'h10, 64'h0);
        wb(4'hF, 0, 4'hF, 0);
        step();
        chk("rst_valid", 64'(e_valid), 0);
        chk("rst_icode", 64'(e_icode), 1);
        chk("rst_srcA", 64'(e_srcA), 64'hF);
        chk("rst_dstE", 64'(e_dstE), 64'hF);

        ctl(0, 0, 0);
        step();
        chk("irmov_dstE", 64'(e_dstE), 2);
        chk("irmov_valC", e_valC, 64'h10);
        chk("irmov_srcA", 64'(e_srcA), 64'hF);
        chk("irmov_srcB", 64'(e_srcB), 64'hF);
        chk("irmov_valid", 64'(e_valid), 1);

        ins(1, 4'h6, 4'h1, 4'h2, 4'h3, 0, 0);
        wb(4'h2, 64'h10, 4'hF, 0);
        step();
        chk("opq_bypassA", e_valA, 64'h10);
        chk("opq_valB", e_valB, 0);
        chk("opq_dstE", 64'(e_dstE), 3);

        ins(0, 4'h6, 0, 4'h2, 4'h3, 0, 0);
        wb(4'h4, 64'h100, 4'h4, 64'h200);
        step();
        chk("inval_valid", 64'(e_valid), 0);
        ins(1, 4'hB, 0, 4'h1, 4'hF, 0, 0);
        wb(4'hF, 0, 4'hF, 0);
        step();
        chk("pop_valA", e_valA, 64'h200);
        chk("pop_valB", e_valB, 64'h200);
        chk("pop_dstE", 64'(e_dstE), 4);
        chk("pop_dstM", 64'(e_dstM), 1);

        ins(1, 4'h8, 0, 4'hF, 4'hF, 64'h1234, 64'h40);
        step();
        chk("call_valA", e_valA, 64'h40);
        chk("call_valB", e_valB, 64'h200);
        ctl(0, 1, 0);
        ins(1, 4'h3, 0, 4'hF, 4'h9, 64'h99, 0);
        wb(4'h5, 64'h55, 4'hF, 0);
        step();
        chk("stall_valA", e_valA, 64'h40);
        chk("stall_valB", e_valB, 64'h200);
        chk("stall_icode", 64'(e_icode), 8);
        ctl(0, 0, 0);
        ins(1, 4'h2, 0, 4'h5, 4'h6, 0, 0);
        wb(4'hF, 0, 4'hF, 0);
        step();
        chk("wb_in_stall", e_valA, 64'h55);

        ctl(0, 0, 1);
        step();
        chk("bub_valid", 64'(e_valid), 0);
        chk("bub_icode", 64'(e_icode), 1);
        chk("bub_srcA", 64'(e_srcA), 64'hF);
        chk("bub_dstE", 64'(e_dstE), 64'hF);
        ctl(0, 0, 0);
        ins(1, 4'h6, 4'h2, 4'h5, 4'h5, 0, 0);
        step();
        ctl(0, 1, 1);
        ins(1, 4'h9, 0, 4'hF, 4'hF, 0, 0);
        step();
        chk("sb_hold_valid", 64'(e_valid), 1);
        chk("sb_hold_srcA", 64'(e_srcA), 5);

        ctl(0, 0, 0);
        ins(1, 4'hC, 4'h3, 4'h2, 4'h5, 64'h7, 0);
        step();
        chk("err_flag", 64'(e_ins_err), 1);
        chk("err_valid", 64'(e_valid), 1);
        chk("err_srcA", 64'(e_srcA), 64'hF);
        chk("err_dstE", 64'(e_dstE), 64'hF);
        chk("err_valB", e_valB, 0);

        ins(1, 4'h7, 4'h1, 4'hF, 4'hF, 64'h300, 64'h99);
        step();
        chk("jxx_valA", e_valA, 64'h99);
        ins(1, 4'h9, 0, 4'hF, 4'hF, 0, 0);
        step();
        ins(1, 4'h4, 0, 4'h2, 4'h5, 64'h8, 0);
        step();
        ins(1, 4'hA, 0, 4'h5, 4'hF, 0, 0);
        step();
        ins(1, 4'h0, 0, 4'hF, 4'hF, 0, 0);
        step();
        ins(1, 4'h5, 0, 4'h7, 4'h7, 64'h18, 0);
        wb(4'h7, 64'h66, 4'h7, 64'h77);
        step();
        chk("mprio_valB", e_valB, 64'h77);

        ctl(1, 1, 0);
        ins(1, 4'h6, 0, 4'h5, 4'h4, 0, 0);
        wb(4'h5, 64'hAA, 4'hF, 0);
        step();
        chk("mrst_valid", 64'(e_valid), 0);
        chk("mrst_icode", 64'(e_icode), 1);
        ctl(0, 0, 0);
        wb(4'hF, 0, 4'hF, 0);
        step();
        chk("mrst_r5", e_valA, 0);
        chk("mrst_rsp", e_valB, 0);
        ins(1, 4'h2, 0, 4'h7, 4'h1, 0, 0);
        step();
        chk("mrst_r7", e_valA, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
